pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 135 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer between pipeline stages with flush and a
// saturating backpressure counter. in_ready is decoded from state alone to break the ready path.
module pipe_skid_stage #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept_in;
    logic              accept_out;

    // Handshake outputs decoded purely from the state register.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = NOP_VALUE;
        case (state_q)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                out_data  = NOP_VALUE;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                out_data  = main_q;
            end
            TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_data  = main_q;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                out_data  = NOP_VALUE;
            end
        endcase
    end

    assign accept_in  = in_valid & in_ready;
    assign accept_out = out_valid & out_ready;
    assign stall_cnt  = stall_cnt_q;

    // Next-state and storage steering; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_in) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_in && accept_out) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end else if (accept_in) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (accept_out) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (accept_out) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Backpressure counter saturates and ignores flush.
    always_comb begin
        if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table on an 8-bit instance,
// then random traffic on 8-bit and 128-bit instances against a queue-based reference model.
module tb_pipe_skid_stage;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] in_data_b = '0;
    logic [7:0]   in_data_a;

    logic         a_in_ready, a_out_valid;
    logic [7:0]   a_out_data;
    logic [3:0]   a_stall;
    logic         b_in_ready, b_out_valid;
    logic [127:0] b_out_data;
    logic [15:0]  b_stall;

    int tests_run = 0;
    int tests_failed = 0;

    assign in_data_a = in_data_b[7:0];

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(8), .NOP_VALUE(8'hEE), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data_a), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .stall_cnt(a_stall)
    );

    pipe_skid_stage #(.DATA_W(128), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data_b), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .stall_cnt(b_stall)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_st;
    } vec_t;

    vec_t tbl[$];

    // Reference model: FIFO of at most two entries plus an unbounded stall count.
    logic [127:0] mq[$];
    int           mcnt;

    task automatic model_edge();
        int sz;
        sz = mq.size();
        if (sz > 0 && !out_ready) mcnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) mq.push_back(in_data_b);
        end
    endtask

    task automatic model_check();
        logic [127:0] exp_b;
        logic [7:0]   exp_a;
        exp_b = (mq.size() > 0) ? mq[0] : 128'd0;
        exp_a = (mq.size() > 0) ? mq[0][7:0] : 8'hEE;
        chk("rnd_a_in_ready", {127'd0, a_in_ready}, {127'd0, mq.size() < 2});
        chk("rnd_a_out_valid", {127'd0, a_out_valid}, {127'd0, mq.size() > 0});
        chk("rnd_a_out_data", {120'd0, a_out_data}, {120'd0, exp_a});
        chk("rnd_a_stall", {124'd0, a_stall}, (mcnt > 15) ? 128'd15 : 128'(mcnt));
        chk("rnd_b_in_ready", {127'd0, b_in_ready}, {127'd0, mq.size() < 2});
        chk("rnd_b_out_valid", {127'd0, b_out_valid}, {127'd0, mq.size() > 0});
        chk("rnd_b_out_data", b_out_data, exp_b);
        chk("rnd_b_stall", {112'd0, b_stall}, (mcnt > 65535) ? 128'd65535 : 128'(mcnt));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [127:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data_b = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        // Streaming 1..8, then drain.
        for (int i = 1; i <= 8; i++) tbl.push_back('{1'b1, 8'(i), 1'b1, 1'b0, 1'b1, 1'b1, 8'(i), 0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 0});
        // Skid fill, extra stalled beat that must not be taken, then drain.
        tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 0});
        tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1});
        tbl.push_back('{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 2});
        // Flush while in TWO with a beat offered; stall still counts.
        tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 2});
        tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 3});
        tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE, 4});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 4});
        // Flush in ONE with simultaneous accept-in and accept-out.
        tbl.push_back('{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 4});
        tbl.push_back('{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 8'hEE, 4});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 4});
        // Pass-through in ONE.
        tbl.push_back('{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 4});
        tbl.push_back('{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 4});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 4});

        // Reset state, observed while rst is still high.
        #1;
        chk("rst_in_ready", {127'd0, a_in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, a_out_valid}, 128'd0);
        chk("rst_out_data", {120'd0, a_out_data}, 128'hEE);
        chk("rst_stall", {124'd0, a_stall}, 128'd0);
        chk("rst_b_out_data", b_out_data, 128'd0);
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].iv, {120'd0, tbl[i].d}, tbl[i].ordy, tbl[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_in_ready", i), {127'd0, a_in_ready}, {127'd0, tbl[i].e_ir});
            chk($sformatf("vec%0d_out_valid", i), {127'd0, a_out_valid}, {127'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d_out_data", i), {120'd0, a_out_data}, {120'd0, tbl[i].e_od});
            chk($sformatf("vec%0d_stall", i), {124'd0, a_stall}, 128'(tbl[i].e_st));
        end

        // Stall counter saturation on the 4-bit instance; wide instance keeps counting.
        do_reset();
        drive(1'b1, 128'h5A, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 128'h0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_a_stall", {124'd0, a_stall}, 128'd15);
        chk("sat_b_stall", {112'd0, b_stall}, 128'd20);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_a_hold", {124'd0, a_stall}, 128'd15);
        chk("sat_a_data", {120'd0, a_out_data}, 128'h5A);

        // Asynchronous reset between edges while in TWO.
        do_reset();
        drive(1'b1, 128'hAA, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 128'hBB, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("two_in_ready", {127'd0, a_in_ready}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_in_ready", {127'd0, a_in_ready}, 128'd1);
        chk("arst_out_valid", {127'd0, a_out_valid}, 128'd0);
        chk("arst_out_data", {120'd0, a_out_data}, 128'hEE);
        chk("arst_stall", {124'd0, a_stall}, 128'd0);
        chk("arst_b_out_valid", {127'd0, b_out_valid}, 128'd0);
        drive(1'b1, 128'h3C, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_accept_valid", {127'd0, a_out_valid}, 128'd1);
        chk("post_rst_accept_data", {120'd0, a_out_data}, 128'h3C);
        drive(1'b0, 128'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_single", {127'd0, a_out_valid}, 128'd0);

        // Random traffic against the reference model on both widths.
        do_reset();
        mq.delete();
        mcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 9) < 7,
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
            @(posedge clk);
            model_edge();
            #1;
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
